// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter
// Writer side of the scalar register file. Merges the scalar ALU writeback
// stream and a FIFO of vector-to-scalar results into the single write port.
// The selected result is driven one cycle after acceptance. It also keeps a
// pending-destination scoreboard that the issue stage queries.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   alu_valid/ready/rd/data      ALU result stream (accepted on valid & ready)
//   vx_valid/ready/rd/data       vector-to-scalar results, pushed into the FIFO
//   issue_valid, issue_rd        marks issue_rd pending (x0 is ignored)
//   rs1_addr/rs2_addr            hazard query addresses
//   rs1_busy/rs2_busy            pending bit of each queried register
//   write, is_s, rd_addr, data   registered register-file write port
module scalar_wb_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        vx_valid,
   output logic        vx_ready,
   input  logic [4:0]  vx_rd,
   input  logic [31:0] vx_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        write,
   output logic        is_s,
   output logic [4:0]  rd_addr,
   output logic [31:0] data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

   // FIFO storage (small, read combinationally at the head pointer)
   logic [4:0]    mem_rd   [FIFO_DEPTH];
   logic [31:0]   mem_data [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;

   logic          write_q, write_d;
   logic [4:0]    rd_addr_q, rd_addr_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   pending_q, pending_d;

   logic          fifo_nonempty, force_fifo, alu_win, fifo_win, any_win, push;
   logic [4:0]    win_rd;
   logic [31:0]   win_data;

   always_comb begin
      fifo_nonempty = (count_q != '0);
      // Once the ALU has beaten a waiting FIFO entry STARVE_LIMIT times in a
      // row, the ALU is back-pressured for one cycle so the FIFO head drains.
      force_fifo    = fifo_nonempty && (starve_q == STARVE_C);
      alu_ready     = !force_fifo;
      // Full is judged on the registered count only; a pop in the same cycle
      // does not open a slot until the next cycle.
      vx_ready      = (count_q < DEPTH_C);
      push          = vx_valid && vx_ready;
      alu_win       = alu_valid && alu_ready;
      fifo_win      = !alu_win && fifo_nonempty;
      any_win       = alu_win || fifo_win;
      win_rd        = alu_win ? alu_rd   : mem_rd[rd_ptr_q];
      win_data      = alu_win ? alu_data : mem_data[rd_ptr_q];
   end

   always_comb begin
      wr_ptr_d = push     ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = fifo_win ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, fifo_win})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      starve_d = starve_q;
      if (!fifo_nonempty || fifo_win) begin
         starve_d = '0;
      end else if (alu_win && (starve_q < STARVE_C)) begin
         starve_d = starve_q + SW'(1);
      end

      // An x0 destination is consumed but never written; address/data hold.
      write_d   = any_win && (win_rd != 5'd0);
      rd_addr_d = write_d ? win_rd   : rd_addr_q;
      data_d    = write_d ? win_data : data_q;
   end

   // Scoreboard: a new issue to the same register beats the clear caused by
   // an older result, since the new result is still outstanding.
   assign pending_d[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_pending
         logic set_bit, clr_bit;
         assign set_bit = issue_valid && (issue_rd == 5'(gi));
         assign clr_bit = any_win && (win_rd == 5'(gi));
         assign pending_d[gi] = set_bit || (pending_q[gi] && !clr_bit);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr_q]   <= vx_rd;
         mem_data[wr_ptr_q] <= vx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         write_q   <= 1'b0;
         rd_addr_q <= '0;
         data_q    <= '0;
         pending_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         write_q   <= write_d;
         rd_addr_q <= rd_addr_d;
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end

   assign write    = write_q;
   assign is_s     = write_q;
   assign rd_addr  = rd_addr_q;
   assign data     = data_q;
   assign rs1_busy = pending_q[rs1_addr];
   assign rs2_busy = pending_q[rs2_addr];

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed testbench for scalar_wb_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=3).
module tb_scalar_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        vx_valid, vx_ready;
   logic [4:0]  vx_rd;
   logic [31:0] vx_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_busy, rs2_busy;
   logic        write, is_s;
   logic [4:0]  rd_addr;
   logic [31:0] data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scalar_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .vx_valid(vx_valid), .vx_ready(vx_ready), .vx_rd(vx_rd), .vx_data(vx_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .write(write), .is_s(is_s), .rd_addr(rd_addr), .data(data)
   );

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Registered write port check: write/is_s and, when writing, address/data.
   task automatic chk_wr(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".write"}, 32'(write), 32'(w));
      chk({tag, ".is_s"}, 32'(is_s), 32'(w));
      chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(a));
      chk({tag, ".data"}, data, d);
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      vx_valid = 1'b0; vx_rd = '0; vx_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
      rs1_addr = '0; rs2_addr = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      $display("step reset");
      chk_wr("reset", 1'b0, 5'd0, 32'h0);
      chk("reset.alu_ready", 32'(alu_ready), 32'd1);
      chk("reset.vx_ready", 32'(vx_ready), 32'd1);
      chk("reset.rs1_busy", 32'(rs1_busy), 32'd0);

      // 1. single ALU result
      $display("step single_alu rd=5");
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1 chk("t1.alu_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      chk_wr("t1.wb", 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      chk_wr("t1.idle", 1'b0, 5'd5, 32'hDEADBEEF);

      // 2. starvation: one vx entry versus a continuous ALU stream
      $display("step starvation vx rd=7 vs alu rd=3");
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA0;
      vx_valid = 1'b1; vx_rd = 5'd7; vx_data = 32'h11;
      tick();
      vx_valid = 1'b0;
      chk_wr("t2.alu0", 1'b1, 5'd3, 32'hA0);
      for (int i = 0; i < 3; i++) begin
         chk("t2.alu_ready_win", 32'(alu_ready), 32'd1);
         tick();
         chk_wr("t2.alu_win", 1'b1, 5'd3, 32'hA0);
      end
      chk("t2.alu_ready_forced", 32'(alu_ready), 32'd0);
      tick();
      chk_wr("t2.vx_wb", 1'b1, 5'd7, 32'h11);
      chk("t2.alu_ready_back", 32'(alu_ready), 32'd1);
      alu_valid = 1'b0;
      tick();

      // 3. FIFO full with ALU pressure
      $display("step fifo_full");
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA1;
      for (int i = 0; i < 4; i++) begin
         vx_valid = 1'b1; vx_rd = 5'(10 + i); vx_data = 32'h100 + 32'(i);
         #1 chk("t3.vx_ready_fill", 32'(vx_ready), 32'd1);
         tick();
         chk_wr("t3.alu_fill", 1'b1, 5'd3, 32'hA1);
      end
      vx_rd = 5'd14; vx_data = 32'h104;
      #1;
      chk("t3.vx_ready_full", 32'(vx_ready), 32'd0);
      chk("t3.alu_ready_forced", 32'(alu_ready), 32'd0);
      tick();
      chk_wr("t3.pop_a", 1'b1, 5'd10, 32'h100);
      chk("t3.vx_ready_after_pop", 32'(vx_ready), 32'd1);
      chk("t3.alu_ready_after_pop", 32'(alu_ready), 32'd1);
      tick();
      chk_wr("t3.alu_e", 1'b1, 5'd3, 32'hA1);
      vx_valid = 1'b0; alu_valid = 1'b0;
      chk("t3.vx_ready_full2", 32'(vx_ready), 32'd0);
      for (int i = 1; i < 5; i++) begin
         tick();
         chk_wr("t3.drain", 1'b1, 5'(10 + i), 32'h100 + 32'(i));
      end
      tick();
      chk_wr("t3.drained", 1'b0, 5'd14, 32'h104);

      // 4. x0 handling
      $display("step x0");
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      #1 chk("t4.alu_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      chk_wr("t4.no_write", 1'b0, 5'd14, 32'h104);
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      issue_valid = 1'b0; rs1_addr = 5'd0;
      #1 chk("t4.rs1_busy_x0", 32'(rs1_busy), 32'd0);

      // 5. scoreboard
      $display("step scoreboard rd=9");
      issue_valid = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd9;
      #1 chk("t5.no_bypass", 32'(rs1_busy), 32'd0);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("t5.rs1_busy_set", 32'(rs1_busy), 32'd1);
      chk("t5.rs2_busy_set", 32'(rs2_busy), 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      alu_valid = 1'b0; issue_valid = 1'b0;
      chk_wr("t5.wb1", 1'b1, 5'd9, 32'h99);
      chk("t5.set_wins", 32'(rs1_busy), 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9A;
      tick();
      alu_valid = 1'b0;
      chk_wr("t5.wb2", 1'b1, 5'd9, 32'h9A);
      chk("t5.cleared", 32'(rs1_busy), 32'd0);

      // 6. mid-operation reset with 3 queued entries and pending[4]
      $display("step mid_reset");
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
      issue_valid = 1'b1; issue_rd = 5'd4;
      for (int i = 0; i < 3; i++) begin
         vx_valid = 1'b1; vx_rd = 5'(15 + i); vx_data = 32'h200 + 32'(i);
         tick();
         issue_valid = 1'b0;
      end
      vx_valid = 1'b0; alu_valid = 1'b0; rs1_addr = 5'd4;
      #1 chk("t6.pending4", 32'(rs1_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk_wr("t6.reset", 1'b0, 5'd0, 32'h0);
      chk("t6.vx_ready", 32'(vx_ready), 32'd1);
      chk("t6.rs1_busy", 32'(rs1_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_wr("t6.no_stale", 1'b0, 5'd0, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
